// File: rtl/gc_pkg.sv
// Shared GameCube controller constants: poll command, bit
// count, phase multipliers and the transmit state encoding.
package gc_pkg;

    localparam logic [23:0] GC_POLL_CMD  = 24'h400300;
    localparam int          GC_CMD_BITS  = 24;
    localparam int          GC_MUL_SHORT = 1;
    localparam int          GC_MUL_LONG  = 3;
    localparam int          GC_MUL_BIT   = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BIT_LOW,
        ST_BIT_HIGH,
        ST_STOP,
        ST_HOLDOFF
    } gc_state_e;

    function automatic logic [23:0] gc_poll_word(input logic rumble);
        return GC_POLL_CMD | {{(GC_CMD_BITS-1){1'b0}}, rumble};
    endfunction

endpackage

// File: rtl/gc_poll_timer.sv
// Free-running poll period counter with a sticky pending flag
// that the transmitter consumes when it starts a frame.
module gc_poll_timer #(
    parameter int POLL_PERIOD = 1600000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic pending
);

    localparam int CW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(POLL_PERIOD - 1);

    logic [CW-1:0] cnt;
    logic          wrap;

    assign wrap = (cnt == LAST);

    // Period counter; a wrap coinciding with a frame start is absorbed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            pending <= 1'b0;
        end else begin
            cnt     <= wrap ? '0 : cnt + 1'b1;
            pending <= clr ? 1'b0 : (pending | wrap);
        end
    end

endmodule

// File: rtl/gc_transmit.sv
// GameCube poll command serialiser for the open-drain data line.
// Optional auto-poll timer enabled by defining GC_TX_AUTOPOLL_EN.
module gc_transmit
    import gc_pkg::*;
#(
    parameter int CYCLES_PER_US  = 100,
    parameter int HOLDOFF_CYCLES = 40000,
    parameter int POLL_PERIOD    = 1600000
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic rumble,
    output logic data_oe,
    output logic send,
    output logic busy,
    output logic done
);

    localparam int C  = CYCLES_PER_US;
    localparam int PW = $clog2(GC_MUL_LONG * C);
    localparam int HW = (HOLDOFF_CYCLES > 1) ?
                        $clog2(HOLDOFF_CYCLES) : 1;

    localparam logic [PW-1:0] LO_ONE  =
        PW'(GC_MUL_SHORT * C - 1);
    localparam logic [PW-1:0] LO_ZERO =
        PW'(GC_MUL_LONG * C - 1);
    localparam logic [PW-1:0] HI_ONE  =
        PW'((GC_MUL_BIT - GC_MUL_SHORT) * C - 1);
    localparam logic [PW-1:0] HI_ZERO =
        PW'((GC_MUL_BIT - GC_MUL_LONG) * C - 1);
    localparam logic [HW-1:0] HOLD_LAST =
        HW'(HOLDOFF_CYCLES - 1);
    localparam logic [4:0]    FIRST_BIT =
        5'(GC_CMD_BITS - 1);

    gc_state_e     state, state_n;
    logic [PW-1:0] ph, ph_n;
    logic [HW-1:0] ho, ho_n;
    logic [4:0]    idx, idx_n, nxt_idx;
    logic [23:0]   cmd, cmd_n;
    logic          frame_go;
    logic          poll_req;

`ifdef GC_TX_AUTOPOLL_EN
    gc_poll_timer #(
        .POLL_PERIOD (POLL_PERIOD)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (frame_go),
        .pending (poll_req)
    );
`else
    logic unused_poll;
    assign unused_poll = (POLL_PERIOD != 0);
    assign poll_req    = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_n;
    end

    // Next state, phase reloads and command latch
    always_comb begin
        state_n  = state;
        ph_n     = ph;
        ho_n     = ho;
        idx_n    = idx;
        cmd_n    = cmd;
        frame_go = 1'b0;
        nxt_idx  = idx - 5'd1;
        unique case (state)
            ST_IDLE: begin
                if (start || poll_req) begin
                    frame_go = 1'b1;
                    state_n  = ST_BIT_LOW;
                    idx_n    = FIRST_BIT;
                    cmd_n    = gc_poll_word(rumble);
                    ph_n     = cmd_n[GC_CMD_BITS-1] ?
                               LO_ONE : LO_ZERO;
                end
            end
            ST_BIT_LOW: begin
                if (ph == '0) begin
                    state_n = ST_BIT_HIGH;
                    ph_n    = cmd[idx] ? HI_ONE : HI_ZERO;
                end else begin
                    ph_n = ph - 1'b1;
                end
            end
            ST_BIT_HIGH: begin
                if (ph != '0) begin
                    ph_n = ph - 1'b1;
                end else if (idx == '0) begin
                    state_n = ST_STOP;
                    ph_n    = LO_ONE;
                end else begin
                    state_n = ST_BIT_LOW;
                    idx_n   = nxt_idx;
                    ph_n    = cmd[nxt_idx] ? LO_ONE : LO_ZERO;
                end
            end
            ST_STOP: begin
                if (ph == '0) begin
                    state_n = ST_HOLDOFF;
                    ho_n    = HOLD_LAST;
                end else begin
                    ph_n = ph - 1'b1;
                end
            end
            ST_HOLDOFF: begin
                if (ho == '0) state_n = ST_IDLE;
                else          ho_n    = ho - 1'b1;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Datapath registers and outputs decoded from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ph      <= '0;
            ho      <= '0;
            idx     <= '0;
            cmd     <= '0;
            data_oe <= 1'b0;
            send    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            ph      <= ph_n;
            ho      <= ho_n;
            idx     <= idx_n;
            cmd     <= cmd_n;
            data_oe <= (state_n == ST_BIT_LOW) ||
                       (state_n == ST_STOP);
            send    <= (state_n == ST_BIT_LOW)  ||
                       (state_n == ST_BIT_HIGH) ||
                       (state_n == ST_STOP);
            busy    <= (state_n != ST_IDLE);
            done    <= (state_n == ST_HOLDOFF) && (ho_n == '0);
        end
    end

endmodule

// File: tb/tb_gc_transmit.sv
// Directed bench for gc_transmit: frame shape, rumble latch,
// busy lockout, ignored start, async reset and auto-poll.
module tb_gc_transmit;

    localparam int CPU   = 4;
    localparam int HOLD  = 50;
    localparam int PER   = 1000;
    localparam int FRAME = 24 * 4 * CPU + CPU;

    logic clk    = 1'b0;
    logic rst    = 1'b1;
    logic start  = 1'b0;
    logic rumble = 1'b0;
    logic data_oe, send, busy, done;

    int nvec = 0;
    int nerr = 0;
    int cyc;

    typedef struct {
        int bit_no;
        int low;
        int high;
    } vec_t;

    vec_t tbl[25];

    logic w_oe   [0:1023];
    logic w_send [0:1023];
    logic w_done [0:1023];
    int   w_len;
    int   w_idle;

    gc_transmit #(
        .CYCLES_PER_US  (CPU),
        .HOLDOFF_CYCLES (HOLD),
        .POLL_PERIOD    (PER)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .rumble  (rumble),
        .data_oe (data_oe),
        .send    (send),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check(input string name, input int act,
                         input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d",
                     name, act, exp);
        end
    endtask

    // Record one frame from its first busy cycle to busy falling
    task automatic capture();
        int guard;
        w_len  = 0;
        w_idle = 0;
        guard  = 0;
        while (guard < 2000) begin
            @(negedge clk);
            guard++;
            if (busy) begin
                if (w_len < 1024) begin
                    w_oe[w_len]   = data_oe;
                    w_send[w_len] = send;
                    w_done[w_len] = done;
                end
                w_len++;
            end else if (w_len > 0) begin
                break;
            end else begin
                w_idle++;
            end
        end
        if (guard >= 2000) check("capture timeout", guard, 0);
    endtask

    task automatic check_shape(input bit rum1, input string tag);
        int i, lo, hi, hq, ns, nd, el, eh;
        check({tag, " lead"}, w_idle, 0);
        i = 0;
        for (int v = 0; v < 25; v++) begin
            lo = 0;
            while (i < w_len && w_oe[i]) begin
                lo++;
                i++;
            end
            hi = 0;
            while (i < w_len && !w_oe[i] && w_send[i]) begin
                hi++;
                i++;
            end
            el = tbl[v].low;
            eh = tbl[v].high;
            if (v == 23 && rum1) begin
                el = CPU;
                eh = 3 * CPU;
            end
            check($sformatf("%s b%0d low", tag, tbl[v].bit_no),
                  lo, el);
            check($sformatf("%s b%0d high", tag, tbl[v].bit_no),
                  hi, eh);
        end
        hq = 0;
        while (i < w_len && !w_oe[i] && !w_send[i]) begin
            hq++;
            i++;
        end
        check({tag, " holdoff"}, hq, HOLD);
        check({tag, " tail"}, w_len - i, 0);
        ns = 0;
        nd = 0;
        for (int k = 0; k < w_len && k < 1024; k++) begin
            if (w_send[k]) ns++;
            if (w_done[k]) nd++;
        end
        check({tag, " send len"}, ns, FRAME);
        check({tag, " done count"}, nd, 1);
        check({tag, " done last"}, int'(w_done[w_len-1]), 1);
    endtask

    task automatic check_quiet(input string tag);
        int nb;
        nb = 0;
        repeat (30) begin
            @(negedge clk);
            if (busy) nb++;
        end
        check(tag, nb, 0);
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    initial begin : main
        logic [23:0] cmd_exp;
        int rises;
        logic prev;
        cmd_exp = 24'h400300;
        for (int i = 0; i < 24; i++) begin
            tbl[i].bit_no = 23 - i;
            tbl[i].low    = cmd_exp[23-i] ? CPU : 3 * CPU;
            tbl[i].high   = cmd_exp[23-i] ? 3 * CPU : CPU;
        end
        tbl[24].bit_no = 99;
        tbl[24].low    = CPU;
        tbl[24].high   = 0;

        repeat (3) @(negedge clk);
        check("reset data_oe", int'(data_oe), 0);
        check("reset send", int'(send), 0);
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        rst = 1'b0;

`ifdef GC_TX_AUTOPOLL_EN
        wait_cyc(PER);
        check("ap before wrap", int'(busy), 0);
        wait_cyc(PER + 1);
        check("ap frame 1", int'(busy), 1);
        wait_cyc(2 * PER - 1);
        check("ap idle before 2", int'(busy), 0);
        start = 1'b1;
        wait_cyc(2 * PER);
        start = 1'b0;
        check("ap coincident start", int'(busy), 1);
        rises = 0;
        prev  = busy;
        while (cyc < 3 * PER - 1) begin
            @(negedge clk);
            if (busy && !prev) rises++;
            prev = busy;
        end
        check("ap single frame", rises, 0);
        check("ap idle before 3", int'(busy), 0);
        wait_cyc(3 * PER + 1);
        check("ap frame 3", int'(busy), 1);
`else
        @(negedge clk);
        rumble = 1'b0;
        start  = 1'b1;
        fork
            capture();
            begin
                @(posedge clk);
                #1 start = 1'b0;
            end
        join
        check_shape(1'b0, "shape");

        rumble = 1'b1;
        start  = 1'b1;
        fork
            capture();
            begin
                @(posedge clk);
                #1 start = 1'b0;
                repeat (150) @(negedge clk);
                rumble = 1'b0;
            end
        join
        check_shape(1'b1, "rumble");

        start = 1'b1;
        fork
            capture();
            begin
                @(posedge clk);
                #1 start = 1'b0;
                repeat (99) @(negedge clk);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        join
        check_shape(1'b0, "ignored");
        check_quiet("ignored no frame");

        start = 1'b1;
        capture();
        check_shape(1'b0, "lock1");
        fork
            capture();
            begin
                repeat (20) @(negedge clk);
                start = 1'b0;
            end
        join
        check_shape(1'b0, "lock2");
        check_quiet("lock quiet");

        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (260) @(negedge clk);
        check("pre-reset data_oe", int'(data_oe), 1);
        #2 rst = 1'b1;
        #1;
        check("async rst data_oe", int'(data_oe), 0);
        check("async rst send", int'(send), 0);
        check("async rst busy", int'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        start = 1'b1;
        fork
            capture();
            begin
                @(posedge clk);
                #1 start = 1'b0;
            end
        join
        check_shape(1'b0, "after rst");
`endif
        $display("== %0d vectors applied, %0d miscompares ==",
                 nvec, nerr);
        $finish;
    end

endmodule

// File: doc/gc_transmit.md
# gc_transmit

Upstream stage of the GameCube controller path. Serialises the 24-bit poll command onto the open-drain single-wire controller bus, MSB first, using GameCube bit encoding. Asserts `send` to `gc_receive` for the whole command so the receiver's bit counter stays cleared. Drops `send` exactly when the stop bit releases the line, so the receiver catches the controller's first response edge.

## Interface
- `CYCLES_PER_US`, default 100: clk cycles per microsecond. Must match `gc_receive`'s 200-cycle (2 us) sample point at 100 MHz.
- `HOLDOFF_CYCLES`, default 40000: post-frame quiet time reserved for the 64-bit response. Range 1..2^20.
- `POLL_PERIOD`, default 1600000: auto-poll interval in cycles. Used only with `GC_TX_AUTOPOLL_EN`.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: request one poll frame. Sampled only in IDLE.
- `rumble` in 1: value of command bit 0. Latched on frame start.
- `data_oe` out 1: 1 = pull bus low; 0 = release (pad tristates, pull-up).
- `send` out 1: high while the command is being driven. Feeds `gc_receive.send`.
- `busy` out 1: high from frame start until holdoff expires.
- `done` out 1: one-cycle pulse on the last holdoff cycle.

## Operation
- Command word: 0x4003 in the top 16 bits, 0x0 in bits 7:1, `rumble` latched in bit 0 (0x400300 or 0x400301). Sent MSB first.
- Bit encoding, bit period 4 us:
  - '0' = 3 us low, then 1 us released.
  - '1' = 1 us low, then 3 us released.
  - Stop bit = 1 us low, then release.
- States:
  - IDLE: on `start` go to BIT_LOW, bit index 23.
  - BIT_LOW -> BIT_HIGH when its low time expires.
  - BIT_HIGH -> BIT_LOW with index-1 when its high time expires; from index 0 go to STOP.
  - STOP -> HOLDOFF after 1 us low.
  - HOLDOFF -> IDLE after `HOLDOFF_CYCLES`.
- Outputs by state:
  - `data_oe` = 1 in BIT_LOW and STOP, 0 elsewhere.
  - `send` = 1 in BIT_LOW, BIT_HIGH and STOP.
  - `busy` = 1 in every state except IDLE.
- `start` outside IDLE is ignored, not queued. `rumble` changes mid-frame have no effect.
- Phase counter width: $clog2(3*CYCLES_PER_US). It reloads to terminal-1 on each phase entry and counts down to 0.
- Async reset: all outputs 0 immediately, state IDLE, bus released, even mid-bit.

## Timing
- Reset values: `data_oe`=0, `send`=0, `busy`=0, `done`=0. All outputs are registered.
- `start` high at edge N gives `data_oe`=`send`=`busy`=1 from cycle N+1.
- Frame length (`send` high): 24*4*CYCLES_PER_US + CYCLES_PER_US cycles, i.e. 9700 at defaults.
- Low phases are exactly 1*CYCLES_PER_US or 3*CYCLES_PER_US cycles; high phases are the complement to 4*CYCLES_PER_US.
- `send` and `data_oe` fall on the same edge at the end of STOP.
- `done` pulses on the last HOLDOFF cycle. `busy` falls on the next cycle.
- Earliest next frame starts on the cycle after `busy` falls, when `start` is held high.

## Configuration
- `GC_TX_AUTOPOLL_EN` defined:
  - Free-running counter wraps every `POLL_PERIOD` cycles after reset and sets a pending flag on wrap.
  - Pending flag starts a frame from IDLE exactly like `start`, then clears on that frame start.
  - `start` and pending in the same cycle give one frame. Pending set during a frame is held until IDLE.
  - `rumble` is latched as usual.
- Not defined: frames start only from `start`. No timer logic is synthesised. `POLL_PERIOD` is ignored.

## Structure
- Shared package `gc_pkg`:
  - Poll command base 24'h400300.
  - Bit count 24.
  - Phase multipliers 1/3/4.
  - State encoding IDLE/BIT_LOW/BIT_HIGH/STOP/HOLDOFF.
  - `gc_receive` reuses the constants.
- One sub-module, `gc_poll_timer` (period counter plus pending flag). Instantiated only under `GC_TX_AUTOPOLL_EN`.

## Test plan
All scenarios use CYCLES_PER_US=4, HOLDOFF_CYCLES=50.
- Frame shape: `start` pulse with `rumble`=0.
  - Bus shows 0x400300 MSB first: bit 23 = 12 low/4 high, bit 22 = 4 low/12 high.
  - Then stop 4 low. `send` high for exactly 388 cycles.
- Rumble: `rumble`=1 at start, then toggled to 0 mid-frame -> bit 0 is encoded '1' (4 low/12 high).
- Busy lockout: `start` held high continuously.
  - Frames are separated by exactly the 50-cycle holdoff.
  - `done` pulses once per frame, on the cycle before `busy` falls.
- Ignored start: `start` pulse at cycle 100 of a frame -> no extra frame and no change to bus waveform.
- Reset mid-op: `rst` asserted during a bit-7 low phase.
  - `data_oe`, `send`, `busy` go 0 without waiting for a clock edge.
  - A `start` after release gives a full clean frame.
- Autopoll (macro on, POLL_PERIOD=1000):
  - Frames begin at cycles 1001, 2001, ... after reset release.
  - `start` coincident with the timer wrap gives a single frame.
